set_dispatch: RTL and testbench

Request dispatcher sitting directly upstream of the set element-count counter (central/radius/mode in, candidate out). It buffers incoming count requests in a small FIFO and issues them one at a time on the counter's en/busy interface. It returns each candidate count, tagged, on a valid/ready result port. It also rejects reserved modes locally so the counter never sees them.

---
 rtl/set_pkg.sv | 21 ++
 rtl/set_req_fifo.sv | 45 ++++
 rtl/set_dispatch.sv | 183 ++++++++++++++++++
 tb/tb_set_dispatch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_pkg.sv
// Shared constants and types for the set_dispatch request dispatcher.
package set_pkg;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int CAND_W    = 8;

  localparam logic [1:0] MODE_A   = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_REJECT    = 3'd4
  } state_t;

endpackage

// File: rtl/set_req_fifo.sv
// Request FIFO for set_dispatch; wrap-bit pointers, head visible combinationally.
module set_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/set_dispatch.sv
// Buffers count requests, issues them one at a time to the set counter, returns tagged results.
// Optional watchdog on the counter wait states: define SET_DISPATCH_TIMEOUT_EN.
module set_dispatch
  import set_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CENTRAL_W-1:0] req_central,
  input  logic [RADIUS_W-1:0]  req_radius,
  input  logic [1:0]           req_mode,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [1:0]           set_mode,
  input  logic                 set_busy,
  input  logic [CAND_W-1:0]    set_candidate,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CAND_W-1:0]    res_candidate,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_err,
  output state_t               fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and offered data stays stable until transferred.

  localparam int ENT_W = TAG_W + 2 + RADIUS_W + CENTRAL_W;

  state_t               state;
  state_t               next_state;
  logic                 full;
  logic                 empty;
  logic [ENT_W-1:0]     head;
  logic [CENTRAL_W-1:0] head_central;
  logic [RADIUS_W-1:0]  head_radius;
  logic [1:0]           head_mode;
  logic [TAG_W-1:0]     head_tag;
  logic                 fifo_pop;
  logic                 load_issue;
  logic                 load_tag;
  logic                 done_ok;
  logic                 done_err;
  logic                 timeout_hit;

  assign req_ready = !full;
  assign fsm_state = state;

  set_req_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (fifo_pop),
    .din   ({req_tag, req_mode, req_radius, req_central}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign head_central = head[CENTRAL_W-1:0];
  assign head_radius  = head[CENTRAL_W +: RADIUS_W];
  assign head_mode    = head[CENTRAL_W+RADIUS_W +: 2];
  assign head_tag     = head[ENT_W-1 -: TAG_W];

`ifdef SET_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             waiting;

  assign waiting     = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
  assign timeout_hit = waiting && (wd_cnt >= CNT_W'(TIMEOUT - 1));

  // Counts cycles spent waiting on the counter; saturates once the limit is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (!waiting) begin
      wd_cnt <= '0;
    end else if (!timeout_hit) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (!empty && !res_valid)
          next_state = (head_mode == MODE_RSV) ? S_REJECT : S_ISSUE;
      end
      S_ISSUE:     next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (set_busy)         next_state = S_WAIT_DONE;
        else if (timeout_hit) next_state = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (!set_busy || timeout_hit) next_state = S_IDLE;
      end
      S_REJECT:    next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    set_en     = 1'b0;
    fifo_pop   = 1'b0;
    load_issue = 1'b0;
    load_tag   = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        load_tag   = !empty && !res_valid;
        load_issue = !empty && !res_valid && (head_mode != MODE_RSV);
      end
      S_ISSUE: begin
        set_en   = 1'b1;
        fifo_pop = 1'b1;
      end
      S_WAIT_BUSY: done_err = !set_busy && timeout_hit;
      S_WAIT_DONE: begin
        done_ok  = !set_busy;
        done_err = set_busy && timeout_hit;
      end
      S_REJECT: begin
        fifo_pop = 1'b1;
        done_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter-facing fields only change when leaving IDLE, so they stay put for a whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_central <= '0;
      set_radius  <= '0;
      set_mode    <= '0;
      res_tag     <= '0;
    end else begin
      if (load_issue) begin
        set_central <= head_central;
        set_radius  <= head_radius;
        set_mode    <= head_mode;
      end
      if (load_tag) res_tag <= head_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_err       <= 1'b0;
    end else if (done_ok) begin
      res_valid     <= 1'b1;
      res_candidate <= set_candidate;
      res_err       <= 1'b0;
    end else if (done_err) begin
      res_valid     <= 1'b1;
      res_candidate <= '0;
      res_err       <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_set_dispatch.sv
// Directed bench for set_dispatch with a behavioural set-counter model and a result scoreboard.
// Watchdog vectors run only when SET_DISPATCH_TIMEOUT_EN is defined.
module tb_set_dispatch;
  import set_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic [CENTRAL_W-1:0] req_central;
  logic [RADIUS_W-1:0]  req_radius;
  logic [1:0]           req_mode;
  logic [TAG_W-1:0]     req_tag;
  logic                 set_en;
  logic [CENTRAL_W-1:0] set_central;
  logic [RADIUS_W-1:0]  set_radius;
  logic [1:0]           set_mode;
  logic                 set_busy;
  logic [CAND_W-1:0]    set_candidate;
  logic                 res_valid;
  logic                 res_ready;
  logic [CAND_W-1:0]    res_candidate;
  logic [TAG_W-1:0]     res_tag;
  logic                 res_err;
  state_t               fsm_state;

  set_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_central   (req_central),
    .req_radius    (req_radius),
    .req_mode      (req_mode),
    .req_tag       (req_tag),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .set_busy      (set_busy),
    .set_candidate (set_candidate),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_candidate (res_candidate),
    .res_tag       (res_tag),
    .res_err       (res_err),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({req_ready, set_en, set_central, set_radius, set_mode,
                res_valid, res_candidate, res_tag, res_err});
  endfunction

  localparam logic [63:0] RST_VEC = 64'(1) << 53;

  // ---------------- set-counter model ----------------
  logic [CAND_W-1:0] cand_q[$];
  int  busy_len = 1;
  bit  no_busy  = 1'b0;
  int  hold;

  always @(posedge clk or posedge rst) begin
    logic [CAND_W-1:0] c;
    if (rst) begin
      set_busy      <= 1'b0;
      set_candidate <= '0;
      hold          <= 0;
    end else if (set_en) begin
      c = 8'hEE;
      if (cand_q.size() != 0) c = cand_q.pop_front();
      if (!no_busy) begin
        set_busy      <= 1'b1;
        hold          <= busy_len - 1;
        set_candidate <= c;
      end
    end else if (set_busy) begin
      if (hold == 0) set_busy <= 1'b0;
      else           hold <= hold - 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];   // {err, tag, candidate}
  int en_count = 0;

  always @(negedge clk) begin
    logic [12:0] e;
    #2;
    if (!rst) begin
      if (set_en) begin
        en_count++;
        check("en_while_res_valid", 64'(res_valid), 64'(0));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(res_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_candidate", 64'(res_candidate), 64'(e[7:0]));
          check("sb_tag",       64'(res_tag),       64'(e[11:8]));
          check("sb_err",       64'(res_err),       64'(e[12]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                      input logic [3:0] t, input logic [7:0] cand, input bit err,
                      output int t_acc, output bit stalled);
    int n = 0;
    req_central = c;
    req_radius  = r;
    req_mode    = m;
    req_tag     = t;
    req_valid   = 1'b1;
    stalled     = 1'b0;
    while (!req_ready && n < 100) begin
      stalled = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_ready_timeout", 64'(req_ready), 64'(1));
    t_acc = cyc;
    exp_q.push_back({err, t, err ? 8'd0 : cand});
    if (m != MODE_RSV) cand_q.push_back(cand);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_res(input int limit);
    int n = 0;
    while (!res_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check("res_valid_timeout", 64'(res_valid), 64'(1));
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    int t0, r0, en0, en1, first_stall;
    bit st;

    rst = 1'b1; req_valid = 1'b0; req_central = '0; req_radius = '0;
    req_mode = '0; req_tag = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), RST_VEC);
    check("reset_state", 64'(fsm_state), 64'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Single request: issue at T+2, result at T+5.
    push(24'h440000, 12'h300, MODE_A, 4'h5, 8'd29, 1'b0, t0, st);
    check("t1_en_T1", 64'(set_en), 64'(0));
    @(negedge clk);
    check("t1_en_T2", 64'(set_en), 64'(1));
    check("t1_fields_T2", 64'({set_central, set_radius, set_mode}), 64'({24'h440000, 12'h300, MODE_A}));
    @(negedge clk);
    check("t1_en_T3", 64'(set_en), 64'(0));
    check("t1_state_T3", 64'(fsm_state), 64'(S_WAIT_BUSY));
    @(negedge clk);
    check("t1_valid_T4", 64'(res_valid), 64'(0));
    check("t1_fields_T4", 64'({set_central, set_radius, set_mode}), 64'({24'h440000, 12'h300, MODE_A}));
    @(negedge clk);
    check("t1_cycle_T5", 64'(cyc), 64'(t0 + 5));
    check("t1_result_T5", 64'({res_valid, res_candidate, res_err, res_tag}), 64'({1'b1, 8'd29, 1'b0, 4'h5}));
    res_ready = 1'b1;
    @(negedge clk);
    check("t1_valid_clear", 64'(res_valid), 64'(0));
    check("t1_en_count", 64'(en_count), 64'(1));
    res_ready = 1'b0;

    // Lone reserved mode: REJECT at T+2, result at T+3, counter untouched.
    push(24'h123400, 12'h450, MODE_RSV, 4'h9, 8'd0, 1'b1, t0, st);
    check("rsv_valid_T1", 64'(res_valid), 64'(0));
    @(negedge clk);
    check("rsv_state_T2", 64'(fsm_state), 64'(S_REJECT));
    check("rsv_valid_T2", 64'(res_valid), 64'(0));
    @(negedge clk);
    check("rsv_result_T3", 64'({res_valid, res_candidate, res_err, res_tag}), 64'({1'b1, 8'd0, 1'b1, 4'h9}));
    check("rsv_fields_kept", 64'({set_central, set_radius, set_mode}), 64'({24'h440000, 12'h300, MODE_A}));
    check("rsv_no_en", 64'(en_count), 64'(1));
    res_ready = 1'b1;
    @(negedge clk);

    // Burst of six: the head leaves at ISSUE, so five pushes fit before the first stall.
    en0 = en_count;
    first_stall = 0;
    for (int i = 0; i < 6; i++) begin
      push(24'(24'h111100 * (i + 1)), 12'(12'h120 + i), 2'(i % 3), 4'(i + 1), 8'(10 + i), 1'b0, t0, st);
      if (st && first_stall == 0) first_stall = i + 1;
    end
    check("burst_first_stall", 64'(first_stall), 64'(6));
    wait_drain(200);
    check("burst_en_count", 64'(en_count - en0), 64'(6));

    // Reserved mode sandwiched between two valid requests.
    en0 = en_count;
    push(24'h220000, 12'h210, MODE_AND, 4'h1, 8'd40, 1'b0, t0, st);
    push(24'h330000, 12'h220, MODE_RSV, 4'h2, 8'd0,  1'b1, t0, st);
    push(24'h440000, 12'h230, MODE_XOR, 4'h3, 8'd41, 1'b0, t0, st);
    wait_drain(100);
    check("sandwich_en_count", 64'(en_count - en0), 64'(2));

    // Result held for 10 cycles with more queued; next ISSUE two cycles after release.
    res_ready = 1'b0;
    push(24'h510000, 12'h310, MODE_A, 4'h4, 8'd11, 1'b0, t0, st);
    push(24'h520000, 12'h320, MODE_A, 4'h5, 8'd22, 1'b0, t0, st);
    push(24'h530000, 12'h330, MODE_A, 4'h6, 8'd33, 1'b0, t0, st);
    wait_res(50);
    en1 = en_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result", 64'({res_valid, res_candidate, res_tag, res_err}), 64'({1'b1, 8'd11, 4'h4, 1'b0}));
    end
    check("hold_no_issue", 64'(en_count), 64'(en1));
    res_ready = 1'b1;
    r0 = cyc;
    @(negedge clk);
    check("release_en_R1", 64'(set_en), 64'(0));
    @(negedge clk);
    check("release_cycle_R2", 64'(cyc), 64'(r0 + 2));
    check("release_en_R2", 64'(set_en), 64'(1));
    wait_drain(100);

`ifdef SET_DISPATCH_TIMEOUT_EN
    // Counter never goes busy: error result after TIMEOUT cycles in WAIT_BUSY.
    res_ready = 1'b0;
    no_busy   = 1'b1;
    push(24'h610000, 12'h410, MODE_A, 4'h7, 8'h55, 1'b1, t0, st);
    repeat (TIMEOUT + 1) @(negedge clk);
    check("to_valid_early", 64'(res_valid), 64'(0));
    check("to_state_wait", 64'(fsm_state), 64'(S_WAIT_BUSY));
    @(negedge clk);
    check("to_result", 64'({res_valid, res_candidate, res_err, res_tag}), 64'({1'b1, 8'd0, 1'b1, 4'h7}));
    no_busy   = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    push(24'h620000, 12'h420, MODE_XOR, 4'h8, 8'd63, 1'b0, t0, st);
    wait_drain(100);
`endif

    // Reset during WAIT_DONE abandons the operation and empties the FIFO.
    busy_len = 6;
    push(24'h710000, 12'h510, MODE_A, 4'h8, 8'd77, 1'b0, t0, st);
    push(24'h720000, 12'h520, MODE_AND, 4'h9, 8'd78, 1'b0, t0, st);
    begin
      int n = 0;
      while (fsm_state != S_WAIT_DONE && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("rst_reach_wait_done", 64'(fsm_state), 64'(S_WAIT_DONE));
    end
    rst = 1'b1;
    #1;
    check("midrst_outputs", out_vec(), RST_VEC);
    check("midrst_state", 64'(fsm_state), 64'(S_IDLE));
    exp_q.delete();
    cand_q.delete();
    busy_len = 1;
    @(negedge clk);
    rst = 1'b0;
    en0 = en_count;
    repeat (8) @(negedge clk);
    check("postrst_no_issue", 64'(en_count), 64'(en0));
    check("postrst_idle", 64'({req_ready, res_valid, fsm_state}), 64'({1'b1, 1'b0, S_IDLE}));
    push(24'h730000, 12'h530, MODE_A, 4'hA, 8'd5, 1'b0, t0, st);
    wait_drain(100);
    check("postrst_en_count", 64'(en_count - en0), 64'(1));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
